// File: rtl/id_ex_if.sv
// id_ex_if: ID->EX stage bundle; forwarding signals exist only with ID_EX_FORWARD_EN
interface id_ex_if;
  logic        RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, RegDst_i;
  logic [1:0]  ALUOp_i;
  logic [31:0] RSdata_i, RTdata_i, imm_i;
  logic [4:0]  RSaddr_i, RTaddr_i, RDaddr_i;
  logic [5:0]  funct_i;
  logic        RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, RegDst_o, valid_o;
  logic [1:0]  ALUOp_o;
  logic [31:0] RSdata_o, RTdata_o, imm_o, ALUdata1_o, ALUdata2_o;
  logic [4:0]  RSaddr_o, RTaddr_o, RDaddr_o, WBaddr_o;
  logic [5:0]  funct_o;
`ifdef ID_EX_FORWARD_EN
  logic [1:0]  ForwardA_i, ForwardB_i;
  logic [31:0] EXMEMdata_i, MEMWBdata_i;
`endif
  modport master (
`ifdef ID_EX_FORWARD_EN
    output ForwardA_i, ForwardB_i, EXMEMdata_i, MEMWBdata_i,
`endif
    output RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, RegDst_i, ALUOp_i,
    output RSdata_i, RTdata_i, imm_i, RSaddr_i, RTaddr_i, RDaddr_i, funct_i,
    input  RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, RegDst_o, valid_o, ALUOp_o,
    input  RSdata_o, RTdata_o, imm_o, ALUdata1_o, ALUdata2_o,
    input  RSaddr_o, RTaddr_o, RDaddr_o, WBaddr_o, funct_o
  );
  modport slave (
`ifdef ID_EX_FORWARD_EN
    input  ForwardA_i, ForwardB_i, EXMEMdata_i, MEMWBdata_i,
`endif
    input  RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, RegDst_i, ALUOp_i,
    input  RSdata_i, RTdata_i, imm_i, RSaddr_i, RTaddr_i, RDaddr_i, funct_i,
    output RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, RegDst_o, valid_o, ALUOp_o,
    output RSdata_o, RTdata_o, imm_o, ALUdata1_o, ALUdata2_o,
    output RSaddr_o, RTaddr_o, RDaddr_o, WBaddr_o, funct_o
  );
endinterface

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register with stall/flush; define ID_EX_FORWARD_EN for EX operand forwarding
module id_ex_reg (
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    stall_i,
  input  logic    flush_i,
  id_ex_if.slave  bus
);
  logic [125:0] d, q;
  logic [31:0]  fwd_a, fwd_b;
  assign d = {1'b1, bus.RegWrite_i, bus.MemtoReg_i, bus.MemRead_i, bus.MemWrite_i,
              bus.ALUSrc_i, bus.RegDst_i, bus.ALUOp_i, bus.RSdata_i, bus.RTdata_i, bus.imm_i,
              bus.RSaddr_i, bus.RTaddr_i, bus.RDaddr_i, bus.funct_i};
  assign {bus.valid_o, bus.RegWrite_o, bus.MemtoReg_o, bus.MemRead_o, bus.MemWrite_o,
          bus.ALUSrc_o, bus.RegDst_o, bus.ALUOp_o, bus.RSdata_o, bus.RTdata_o, bus.imm_o,
          bus.RSaddr_o, bus.RTaddr_o, bus.RDaddr_o, bus.funct_o} = q;
  // a bubble is the all-zero word: no write, no memory access, valid low
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) q <= '0;
    else if (flush_i) q <= '0;
    else if (!stall_i) q <= d;
`ifdef ID_EX_FORWARD_EN
  assign fwd_a = bus.ForwardA_i == 2'b10 ? bus.EXMEMdata_i :
                 bus.ForwardA_i == 2'b01 ? bus.MEMWBdata_i : bus.RSdata_o;
  assign fwd_b = bus.ForwardB_i == 2'b10 ? bus.EXMEMdata_i :
                 bus.ForwardB_i == 2'b01 ? bus.MEMWBdata_i : bus.RTdata_o;
`else
  assign fwd_a = bus.RSdata_o;
  assign fwd_b = bus.RTdata_o;
`endif
  assign bus.ALUdata1_o = fwd_a;
  assign bus.ALUdata2_o = bus.ALUSrc_o ? bus.imm_o : fwd_b;
  assign bus.WBaddr_o   = bus.RegDst_o ? bus.RDaddr_o : bus.RTaddr_o;
endmodule
